// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the serial-link deserializer.
package deser_pkg;

    localparam int DESER_DATA_W = 16;
    localparam int DESER_LEN_W  = $clog2(DESER_DATA_W) + 1;
    // Shortest burst the serializer ever produces.
    localparam int MIN_LEN      = 3;

    typedef enum logic {IDLE, COLLECT} deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Rebuilds left-aligned parallel words from an MSB-first, valid-framed bit stream; 1 pulse per burst.
// Optional macro DESER_MINLEN_CHK_EN adds deser_err_o, flagging bursts shorter than MIN_LEN.
module deserializer
    import deser_pkg::*;
#(
    parameter  int DATA_W = DESER_DATA_W,
    localparam int LEN_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [LEN_W-1:0]  deser_len_o,
    output logic              deser_data_val_o
`ifdef DESER_MINLEN_CHK_EN
    ,
    output logic              deser_err_o
`endif
);

    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    deser_state_t      state_q;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, emit_data_d;
    logic [LEN_W-1:0]  len_q, emit_len_d;
    logic              vld_q;
    logic              full_d;

    // The shift register is zero between words, so inserting a bit is an OR at position cnt_q.
    always_comb begin
        shreg_d     = shreg_q | (data_i ? (MSB_MASK >> cnt_q) : '0);
        cnt_d       = cnt_q + LEN_W'(1);
        full_d      = (cnt_d == LEN_W'(DATA_W));
        emit_data_d = data_val_i ? shreg_d : shreg_q;
        emit_len_d  = data_val_i ? cnt_d : cnt_q;
    end

`ifdef DESER_MINLEN_CHK_EN
    logic err_q;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            vld_q   <= 1'b0;
`ifdef DESER_MINLEN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
`ifdef DESER_MINLEN_CHK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (data_val_i) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_d;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (data_val_i && !full_d) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_d;
                    end else begin
                        // Either the burst ended or the word filled up; a full word
                        // includes the bit arriving this cycle.
                        data_q  <= emit_data_d;
                        len_q   <= emit_len_d;
                        vld_q   <= 1'b1;
`ifdef DESER_MINLEN_CHK_EN
                        err_q   <= (emit_len_d < LEN_W'(MIN_LEN));
`endif
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign deser_data_o     = data_q;
    assign deser_len_o      = len_q;
    assign deser_data_val_o = vld_q;
`ifdef DESER_MINLEN_CHK_EN
    assign deser_err_o      = err_q;
`endif

endmodule
